vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
Generates VGA raster timing for the 800x600@60 Hz mode from the 40 MHz pixel clock. It sits directly upstream of the colour/sync output stage of the top level. It supplies HSYNC/VSYNC plus pixel coordinates and the active-video flag that the game renderer uses to produce COLOR. All outputs are registered and mutually aligned, so downstream logic samples coordinates and syncs from the same cycle.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, horizontal sync width (pixels)
H_BP, 88, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width (lines)
V_BP, 23, vertical back porch (lines)
SYNC_POL, 1, sync asserted level (1 = positive pulse)

Ports:
CLK_40M  in  1  pixel clock, 40 MHz
RESET  in  1  asynchronous, active-high reset
HSYNC  out  1  horizontal sync, level SYNC_POL when asserted
VSYNC  out  1  vertical sync, level SYNC_POL when asserted
ACTIVE  out  1  high while (X < H_ACTIVE) and (Y < V_ACTIVE)
X  out  11  horizontal counter, 0..H_TOTAL-1
Y  out  10  vertical counter, 0..V_TOTAL-1
LINE_START  out  1  one-cycle pulse when X == 0
FRAME_START  out  1  one-cycle pulse when X == 0 and Y == 0
COLOR  out  8  RGB332 test pattern (see Optional Feature)

Behaviour:
- Clocking and reset: one clock, CLK_40M. RESET is asynchronous and active-high.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628).
- Reset values, held while RESET is high:
  - internal counters h=0, v=0
  - X=0, Y=0
  - HSYNC = VSYNC = ~SYNC_POL
  - ACTIVE=0, LINE_START=0, FRAME_START=0, COLOR=0
- Counters:
  - h increments every clock.
  - When h == H_TOTAL-1, h wraps to 0 and v increments.
  - When v == V_TOTAL-1 and h wraps, v wraps to 0.
  - No enable input; the counters never stall.
- Output stage: one register stage after the counters. All outputs for position (h,v) appear together on the same cycle.
  - On the 1st rising edge after RESET deasserts, outputs show (X=0, Y=0), ACTIVE=1, LINE_START=1, FRAME_START=1.
- HSYNC asserted for X in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], i.e. 840..967.
- VSYNC asserted for whole lines Y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], i.e. 601..604. VSYNC edges coincide with X == 0.
- X and Y report raw counter values during blanking; they are not clamped.
- Widths: X is 11 bits and Y is 10 bits. Parameter sets with H_TOTAL > 2048 or V_TOTAL > 1024 are unsupported.
- Reset mid-frame: outputs return asynchronously to their reset values. Timing restarts at (0,0) after release, with no partial-line artefacts.
- Period checks: exactly one LINE_START per H_TOTAL cycles; exactly one FRAME_START per H_TOTAL*V_TOTAL cycles (663168).

Optional Feature:
Macro VGA_TEST_PATTERN_EN.
- Defined:
  - COLOR shows 8 vertical colour bars, each H_ACTIVE/8 pixels wide.
  - Bar index = X / (H_ACTIVE/8), ordered 8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00.
  - COLOR = 0 whenever ACTIVE = 0.
  - COLOR is registered in the same stage as ACTIVE.
- Undefined: COLOR is tied to 8'h00, and no divider or pattern logic is synthesised.

Test Plan:
- Reset values: hold RESET high for 10 cycles -> HSYNC = VSYNC = 0 (SYNC_POL=1), ACTIVE=0, X=0, Y=0, FRAME_START=0; 1st edge after release -> X=0, Y=0, ACTIVE=1, FRAME_START=1.
- Horizontal timing: run one line -> HSYNC high for exactly 128 cycles starting at X=840; ACTIVE high for 800 cycles; LINE_START period 1056 cycles.
- Vertical timing: run a full frame -> VSYNC high for exactly 4 lines (4224 cycles) starting at Y=601, X=0; FRAME_START period 663168 cycles; Y wraps 627 -> 0.
- Reduced parameters for fast sim: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 -> H_TOTAL=14, V_TOTAL=8; HSYNC at X 10..12; VSYNC at Y 5..6; frame = 112 cycles.
- Reset mid-operation: assert RESET at X=500, Y=300 for 3 cycles -> outputs drop immediately without waiting for a clock; after release the next edge shows X=0, Y=0, FRAME_START=1.
- With VGA_TEST_PATTERN_EN: COLOR=8'hFF at X=0..99, 8'hFC at X=100, 8'h00 at X=799, and 8'h00 at X=800 (blanking).

Source files
------------

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 800x600@60 Hz VGA raster timing from the 40 MHz pixel clock.
//
// A free-running horizontal/vertical counter pair feeds a single register
// stage. Every output for one raster position (h,v) leaves that stage on the
// same cycle. Syncs, coordinates, ACTIVE and COLOR therefore stay aligned.
//
// Optional feature: define VGA_TEST_PATTERN_EN to drive COLOR with eight
// vertical RGB332 colour bars across the active area. Without it, COLOR is
// tied to zero and no pattern logic exists.
//
// Supported range: H_TOTAL <= 2048 and V_TOTAL <= 1024, because X is 11 bits
// and Y is 10 bits. The test pattern also needs H_ACTIVE >= 8.

module vga_timing_gen #(
    parameter int H_ACTIVE = 800,
    parameter int H_FP     = 40,
    parameter int H_SYNC   = 128,
    parameter int H_BP     = 88,
    parameter int V_ACTIVE = 600,
    parameter int V_FP     = 1,
    parameter int V_SYNC   = 4,
    parameter int V_BP     = 23,
    parameter int SYNC_POL = 1
) (
    input  logic        CLK_40M,
    input  logic        RESET,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        ACTIVE,
    output logic [10:0] X,
    output logic [9:0]  Y,
    output logic        LINE_START,
    output logic        FRAME_START,
    output logic [7:0]  COLOR
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST       = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_END    = 11'(H_ACTIVE);
    localparam logic [9:0]  V_ACT_END    = 10'(V_ACTIVE);
    localparam logic [10:0] H_SYNC_START = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0]  V_SYNC_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  V_SYNC_END   = 10'(V_ACTIVE + V_FP + V_SYNC);

    // The asserted level of both syncs. The idle level is its complement.
    localparam logic SYNC_ON = (SYNC_POL != 0);

    // Raster position counters (pre-register stage).
    logic [10:0] h;
    logic [9:0]  v;
    logic        h_last;
    logic        v_last;

    // Decoded values for the current (h,v), registered below.
    logic hsync_d;
    logic vsync_d;
    logic active_d;
    logic line_start_d;
    logic frame_start_d;

    assign h_last = (h == H_LAST);
    assign v_last = (v == V_LAST);

    // Free-running raster counters. The vertical counter advances only when
    // the horizontal counter wraps.
    always_ff @(posedge CLK_40M or posedge RESET) begin
        if (RESET) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= v_last ? '0 : v + 10'd1;
        end else begin
            h <= h + 11'd1;
        end
    end

    // Decode sync windows, active area and start pulses from the counters.
    always_comb begin
        hsync_d       = ~SYNC_ON;
        vsync_d       = ~SYNC_ON;
        active_d      = 1'b0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        if ((h >= H_SYNC_START) && (h < H_SYNC_END)) begin
            hsync_d = SYNC_ON;
        end
        // VSYNC depends only on v. Its edges therefore fall on line boundaries (X == 0).
        if ((v >= V_SYNC_START) && (v < V_SYNC_END)) begin
            vsync_d = SYNC_ON;
        end
        if ((h < H_ACT_END) && (v < V_ACT_END)) begin
            active_d = 1'b1;
        end
        if (h == 11'd0) begin
            line_start_d = 1'b1;
            if (v == 10'd0) begin
                frame_start_d = 1'b1;
            end
        end
    end

    // Output register stage. All outputs for one raster position update together.
    always_ff @(posedge CLK_40M or posedge RESET) begin
        if (RESET) begin
            HSYNC       <= ~SYNC_ON;
            VSYNC       <= ~SYNC_ON;
            ACTIVE      <= 1'b0;
            X           <= '0;
            Y           <= '0;
            LINE_START  <= 1'b0;
            FRAME_START <= 1'b0;
        end else begin
            HSYNC       <= hsync_d;
            VSYNC       <= vsync_d;
            ACTIVE      <= active_d;
            X           <= h;
            Y           <= v;
            LINE_START  <= line_start_d;
            FRAME_START <= frame_start_d;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [10:0] BAR_W = 11'(H_ACTIVE / 8);

    logic [10:0] bar_idx;
    logic [7:0]  bar_color;

    // Map the horizontal position to one of eight RGB332 bars.
    always_comb begin
        bar_idx   = h / BAR_W;
        bar_color = 8'h00;
        case (bar_idx)
            11'd0:   bar_color = 8'hFF;
            11'd1:   bar_color = 8'hFC;
            11'd2:   bar_color = 8'h1F;
            11'd3:   bar_color = 8'h1C;
            11'd4:   bar_color = 8'hE3;
            11'd5:   bar_color = 8'hE0;
            11'd6:   bar_color = 8'h03;
            default: bar_color = 8'h00;
        endcase
    end

    // COLOR shares the output stage with ACTIVE and is black during blanking.
    always_ff @(posedge CLK_40M or posedge RESET) begin
        if (RESET) begin
            COLOR <= 8'h00;
        end else begin
            COLOR <= active_d ? bar_color : 8'h00;
        end
    end
`else
    assign COLOR = 8'h00;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: random-reset bench for vga_timing_gen. It runs two
// instances: the full 800x600 timing (line-level behaviour) and a reduced
// 14x8 raster (frame-level behaviour in a short run). A behavioural model
// derives the expected outputs from the position count since reset release.

module tb_vga_timing_gen;

    // ---------------- clock / reset ----------------
    logic clk;
    logic rst_a;
    logic rst_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT A: full 800x600 timing ----------------
    logic        hs_a, vs_a, act_a, ls_a, fs_a;
    logic [10:0] x_a;
    logic [9:0]  y_a;
    logic [7:0]  col_a;

    vga_timing_gen dut_a (
        .CLK_40M     (clk),
        .RESET       (rst_a),
        .HSYNC       (hs_a),
        .VSYNC       (vs_a),
        .ACTIVE      (act_a),
        .X           (x_a),
        .Y           (y_a),
        .LINE_START  (ls_a),
        .FRAME_START (fs_a),
        .COLOR       (col_a)
    );

    // ---------------- DUT B: reduced 14x8 raster ----------------
    logic        hs_b, vs_b, act_b, ls_b, fs_b;
    logic [10:0] x_b;
    logic [9:0]  y_b;
    logic [7:0]  col_b;

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1)
    ) dut_b (
        .CLK_40M     (clk),
        .RESET       (rst_b),
        .HSYNC       (hs_b),
        .VSYNC       (vs_b),
        .ACTIVE      (act_b),
        .X           (x_b),
        .Y           (y_b),
        .LINE_START  (ls_b),
        .FRAME_START (fs_b),
        .COLOR       (col_b)
    );

    // ---------------- scoreboard counters ----------------
    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            if (tests_failed <= 40)
                $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Packed layout: {hs, vs, act, ls, fs, x[10:0], y[9:0], col[7:0]}.
    function automatic logic [33:0] model(input int ha, input int hf, input int hsw, input int hb,
                                          input int va, input int vf, input int vsw, input int vb,
                                          input int pol, input bit in_reset, input longint p);
        int ht, vt, x, y;
        logic hs, vs, act, ls, fs;
        logic [7:0] col;
        logic [7:0] bars [0:7];
        bars = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};
        if (in_reset) begin
            return {~pol[0], ~pol[0], 1'b0, 1'b0, 1'b0, 11'd0, 10'd0, 8'h00};
        end
        ht  = ha + hf + hsw + hb;
        vt  = va + vf + vsw + vb;
        x   = int'(p % ht);
        y   = int'((p / ht) % vt);
        hs  = (x >= ha + hf && x < ha + hf + hsw) ? pol[0] : ~pol[0];
        vs  = (y >= va + vf && y < va + vf + vsw) ? pol[0] : ~pol[0];
        act = (x < ha) && (y < va);
        ls  = (x == 0);
        fs  = (x == 0) && (y == 0);
        col = 8'h00;
`ifdef VGA_TEST_PATTERN_EN
        if (act) col = bars[x / (ha / 8)];
`endif
        return {hs, vs, act, ls, fs, 11'(x), 10'(y), col};
    endfunction

    // Positions elapsed since reset release: edge k shows position k-1.
    longint k_a = 0;
    longint k_b = 0;

    always @(posedge clk) begin
        k_a = rst_a ? 0 : k_a + 1;
        k_b = rst_b ? 0 : k_b + 1;
    end

    // ---------------- compare process (every cycle, away from posedge) ----------------
    longint gcyc = 0;
    longint last_ls_a = -1;
    longint last_ls_b = -1;
    longint last_fs_b = -1;
    int     hrun_a = 0;
    int     arun_a = 0;
    int     vrun_b = 0;

    always @(negedge clk) begin
        gcyc++;
        check($sformatf("a_outputs@p%0d", k_a - 1),
              {hs_a, vs_a, act_a, ls_a, fs_a, x_a, y_a, col_a},
              model(800, 40, 128, 88, 600, 1, 4, 23, 1, rst_a, k_a - 1));
        check($sformatf("b_outputs@p%0d", k_b - 1),
              {hs_b, vs_b, act_b, ls_b, fs_b, x_b, y_b, col_b},
              model(8, 2, 3, 1, 4, 1, 2, 1, 1, rst_b, k_b - 1));

        // Pulse periods and run lengths observed directly on the outputs.
        if (rst_a) begin
            last_ls_a = -1; hrun_a = 0; arun_a = 0;
        end else begin
            if (ls_a) begin
                if (last_ls_a >= 0) check("a_line_start_period", 64'(gcyc - last_ls_a), 64'd1056);
                last_ls_a = gcyc;
            end
            if (hs_a) hrun_a++;
            else if (hrun_a > 0) begin
                check("a_hsync_width", 64'(hrun_a), 64'd128);
                hrun_a = 0;
            end
            if (act_a) arun_a++;
            else if (arun_a > 0) begin
                check("a_active_width", 64'(arun_a), 64'd800);
                arun_a = 0;
            end
        end
        if (rst_b) begin
            last_ls_b = -1; last_fs_b = -1; vrun_b = 0;
        end else begin
            if (ls_b) begin
                if (last_ls_b >= 0) check("b_line_start_period", 64'(gcyc - last_ls_b), 64'd14);
                last_ls_b = gcyc;
            end
            if (fs_b) begin
                if (last_fs_b >= 0) check("b_frame_start_period", 64'(gcyc - last_fs_b), 64'd112);
                last_fs_b = gcyc;
            end
            if (vs_b) vrun_b++;
            else if (vrun_b > 0) begin
                check("b_vsync_width", 64'(vrun_b), 64'd28);
                vrun_b = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_a(input int x, input int y, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(x_a == 11'(x) && y_a == 10'(y)) && n < budget);
        if (!(x_a == 11'(x) && y_a == 10'(y)))
            check($sformatf("a_wait_timeout_x%0d_y%0d", x, y), {x_a, y_a}, {11'(x), 10'(y)});
    endtask

    task automatic wait_b(input int x, input int y, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(x_b == 11'(x) && y_b == 10'(y)) && n < budget);
        if (!(x_b == 11'(x) && y_b == 10'(y)))
            check($sformatf("b_wait_timeout_x%0d_y%0d", x, y), {x_b, y_b}, {11'(x), 10'(y)});
    endtask

    task automatic run_a();
        int r;
        // First edge after release: origin, active, both start pulses.
        @(negedge clk);
        check("a_first_xy", {x_a, y_a}, 21'd0);
        check("a_first_flags", {act_a, ls_a, fs_a}, 3'b111);
        // HSYNC window edges on line 0.
        wait_a(839, 0, 1100);
        check("a_hsync_before_840", 64'(hs_a), 64'd0);
        @(negedge clk);
        check("a_hsync_at_840", {x_a, hs_a}, {11'd840, 1'b1});
        wait_a(967, 0, 200);
        check("a_hsync_at_967", 64'(hs_a), 64'd1);
        @(negedge clk);
        check("a_hsync_off_968", 64'(hs_a), 64'd0);
        // Blanking outputs are raw counter values; COLOR stays 0 in blanking.
        wait_a(1055, 0, 200);
        check("a_blank_flags", {act_a, col_a}, 9'd0);
        // Mid-line reset at a random position on line 2.
        r = $urandom_range(1, 1055);
        wait_a(r, 2, 3000);
        #2 rst_a = 1'b1;
        #1;
        check("a_async_drop", {hs_a, vs_a, act_a, ls_a, fs_a, x_a, y_a, col_a}, 34'd0);
        repeat (3) @(negedge clk);
        #2 rst_a = 1'b0;
        @(negedge clk);
        check("a_restart", {x_a, y_a, fs_a}, {11'd0, 10'd0, 1'b1});
        repeat (4 * 1056) @(negedge clk);
    endtask

    task automatic run_b();
        int n, hold;
        // Vertical pins on the reduced raster.
        wait_b(0, 5, 200);
        check("b_vsync_y5_x0", 64'(vs_b), 64'd1);
        wait_b(13, 4, 200);
        check("b_vsync_before_y5", 64'(vs_b), 64'd0);
        wait_b(13, 7, 200);
        @(negedge clk);
        check("b_y_wrap", {x_b, y_b, fs_b}, {11'd0, 10'd0, 1'b1});
        // Random resets at random raster positions with random hold times.
        for (int i = 0; i < 12; i++) begin
            n    = $urandom_range(1, 300);
            hold = $urandom_range(1, 4);
            repeat (n) @(negedge clk);
            #2 rst_b = 1'b1;
            #1;
            check("b_async_drop", {hs_b, vs_b, act_b, ls_b, fs_b, x_b, y_b, col_b}, 34'd0);
            repeat (hold) @(negedge clk);
            #2 rst_b = 1'b0;
            @(negedge clk);
            check("b_restart", {x_b, y_b, fs_b}, {11'd0, 10'd0, 1'b1});
        end
        // Several undisturbed frames for the period checks.
        repeat (4 * 112) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (10) @(negedge clk);
        check("a_reset_hold", {hs_a, vs_a, act_a, x_a, y_a, fs_a}, 25'd0);
        #2;
        rst_a = 1'b0;
        rst_b = 1'b0;
        fork
            run_a();
            run_b();
        join
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Watchdog: the whole run is about 9k cycles.
    initial begin
        #1_000_000;
        tests_failed++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog expired");
    end

endmodule
